// File: rtl/enemy_fire_scheduler.sv
// rtl/enemy_fire_scheduler.sv - paces and arbitrates the shared enemy missile among three enemies
module enemy_fire_scheduler #(
    parameter int BASE_CD = 60,
    parameter int CD_STEP = 8,
    parameter int MIN_CD  = 12,
    parameter int TIMEOUT = 180,
    parameter int X_OFF   = 16,
    parameter int Y_OFF   = 32
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [3:0]  level,
    input  logic [2:0]  alive,
    input  logic [32:0] en_x,
    input  logic [32:0] en_y,
    input  logic        missile_done,
    output logic        fire,
    output logic [1:0]  fire_id,
    output logic [10:0] fire_x,
    output logic [10:0] fire_y,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, COOLDOWN, SELECT, FIRE, FLIGHT} state_t;

    localparam logic signed [11:0] BASE_S = 12'(BASE_CD);
    localparam logic signed [11:0] STEP_S = 12'(CD_STEP);
    localparam logic signed [11:0] MIN_S  = 12'(MIN_CD);

    state_t      state, state_nxt;
    logic        vblnk_d, tick;
    logic [3:0]  level_d;
    logic [11:0] cd_cnt, cd_nxt, to_cnt, to_nxt, cd_load;
    logic signed [11:0] cd_raw;
    logic [1:0]  rr_ptr, rr_nxt, sel, sel_nxt, c1, c2;
    logic [1:0]  fire_id_q;
    logic [10:0] fire_x_q, fire_y_q, sx, sy, launch_x, launch_y;
    logic [11:0] sum_x, sum_y;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign tick    = vblnk_in & ~vblnk_d;
    assign cd_raw  = BASE_S - STEP_S * $signed({8'd0, level});
    assign cd_load = (cd_raw < MIN_S) ? 12'(MIN_CD) : cd_raw;
    assign c1      = inc3(rr_ptr);
    assign c2      = inc3(c1);

    always_comb begin
        sx = en_x[32:22];
        sy = en_y[32:22];
        case (sel)
            2'd0:    begin sx = en_x[10:0];  sy = en_y[10:0];  end
            2'd1:    begin sx = en_x[21:11]; sy = en_y[21:11]; end
            default: ;
        endcase
    end

    // Launch coordinates clamp at the right/bottom edge instead of wrapping.
    assign sum_x    = {1'b0, sx} + 12'(X_OFF);
    assign sum_y    = {1'b0, sy} + 12'(Y_OFF);
    assign launch_x = sum_x[11] ? 11'h7ff : sum_x[10:0];
    assign launch_y = sum_y[11] ? 11'h7ff : sum_y[10:0];

    // The pulse and launch data appear in the FIRE cycle itself; a shooter that died
    // since SELECT suppresses the pulse in that same cycle.
    assign fire    = (state == FIRE) && alive[sel];
    assign fire_id = fire ? sel : fire_id_q;
    assign fire_x  = fire ? launch_x : fire_x_q;
    assign fire_y  = fire ? launch_y : fire_y_q;
    assign busy    = fire || (state == FLIGHT);

    always_comb begin
        state_nxt = state;
        cd_nxt    = cd_cnt;
        to_nxt    = to_cnt;
        rr_nxt    = rr_ptr;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (|alive) begin
                    cd_nxt    = cd_load;
                    state_nxt = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (alive == 3'b000) begin
                    state_nxt = IDLE;
                end else if (level != level_d) begin
                    cd_nxt = cd_load;
                end else if (tick) begin
                    cd_nxt = cd_cnt - 12'd1;
                    if (cd_cnt == 12'd1) state_nxt = SELECT;
                end
            end
            SELECT: begin
                state_nxt = FIRE;
                if (alive[c1])          sel_nxt = c1;
                else if (alive[c2])     sel_nxt = c2;
                else if (alive[rr_ptr]) sel_nxt = rr_ptr;
                else                    state_nxt = IDLE;
            end
            FIRE: begin
                if (fire) begin
                    rr_nxt    = sel;
                    to_nxt    = 12'(TIMEOUT);
                    state_nxt = FLIGHT;
                end else begin
                    state_nxt = SELECT;
                end
            end
            FLIGHT: begin
                if (missile_done || (tick && to_cnt == 12'd1)) begin
                    cd_nxt    = cd_load;
                    state_nxt = COOLDOWN;
                end else if (tick) begin
                    to_nxt = to_cnt - 12'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            vblnk_d   <= 1'b0;
            level_d   <= 4'd0;
            cd_cnt    <= 12'd0;
            to_cnt    <= 12'd0;
            rr_ptr    <= 2'd2;
            sel       <= 2'd0;
            fire_id_q <= 2'd0;
            fire_x_q  <= 11'd0;
            fire_y_q  <= 11'd0;
        end else begin
            state   <= state_nxt;
            vblnk_d <= vblnk_in;
            level_d <= level;
            cd_cnt  <= cd_nxt;
            to_cnt  <= to_nxt;
            rr_ptr  <= rr_nxt;
            sel     <= sel_nxt;
            if (fire) begin
                fire_id_q <= sel;
                fire_x_q  <= launch_x;
                fire_y_q  <= launch_y;
            end
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb/tb_enemy_fire_scheduler.sv - directed scoreboard bench for enemy_fire_scheduler
module tb_enemy_fire_scheduler;

    logic        pclk = 1'b0;
    logic        rst, vblnk_in, missile_done;
    logic [3:0]  level;
    logic [2:0]  alive;
    logic [32:0] en_x, en_y;
    logic        fire, busy;
    logic [1:0]  fire_id;
    logic [10:0] fire_x, fire_y;

    typedef struct {
        logic [1:0]  id;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    enemy_fire_scheduler dut (
        .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .level(level), .alive(alive),
        .en_x(en_x), .en_y(en_y), .missile_done(missile_done),
        .fire(fire), .fire_id(fire_id), .fire_x(fire_x), .fire_y(fire_y), .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] sat(input logic [10:0] v, input int off);
        int s;
        s = int'(v) + off;
        return (s > 2047) ? 11'd2047 : 11'(s);
    endfunction

    task automatic push_exp(input logic [1:0] id);
        exp_t e;
        e.id = id;
        e.x  = sat(en_x[11*id +: 11], 16);
        e.y  = sat(en_y[11*id +: 11], 32);
        sb.push_back(e);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk) vblnk_in = 1'b1;
            @(negedge pclk) vblnk_in = 1'b0;
        end
    endtask

    task automatic done_pulse();
        @(negedge pclk) missile_done = 1'b1;
        @(negedge pclk) missile_done = 1'b0;
    endtask

    // n ticks of cooldown, then the fire must land exactly two clocks after the last tick.
    task automatic fire_after(input int n, input logic [1:0] id);
        if (n > 1) run_ticks(n - 1);
        push_exp(id);
        run_ticks(1);
        #1 check("fire_t1", 32'(fire), 32'd0);
        @(negedge pclk); #1;
        check("fire_t2", 32'(fire), 32'd1);
        check("busy_fire", 32'(busy), 32'd1);
        check("fire_id", 32'(fire_id), 32'(id));
        @(negedge pclk); #1;
        check("fire_one_cycle", 32'(fire), 32'd0);
        check("busy_flight", 32'(busy), 32'd1);
        check("fire_id_held", 32'(fire_id), 32'(id));
    endtask

    // Scoreboard side: every observed fire must match the oldest expected launch.
    initial begin
        forever begin
            @(negedge pclk);
            #2;
            if (fire === 1'b1) begin
                check("fire_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_id", 32'(fire_id), 32'(e.id));
                    check("sb_x", 32'(fire_x), 32'(e.x));
                    check("sb_y", 32'(fire_y), 32'(e.y));
                end
            end
        end
    end

    initial begin
        rst          = 1'b0;
        vblnk_in     = 1'b0;
        missile_done = 1'b0;
        level        = 4'd0;
        alive        = 3'b111;
        en_x         = {11'd1000, 11'd500, 11'd100};
        en_y         = {11'd300, 11'd200, 11'd50};
        repeat (3) @(negedge pclk);
        #1;
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(fire_id), 32'd0);
        check("rst_x", 32'(fire_x), 32'd0);
        check("rst_y", 32'(fire_y), 32'd0);
        check("rst_state", 32'(int'(dut.state)), 32'd0);
        rst = 1'b1;

        // Round-robin with all alive at level 0
        fire_after(60, 2'd0); done_pulse();
        fire_after(60, 2'd1); done_pulse();
        fire_after(60, 2'd2); done_pulse();
        fire_after(60, 2'd0); done_pulse();

        // Enemy 1 dead: rotation skips it
        @(negedge pclk) alive = 3'b101;
        fire_after(60, 2'd2); done_pulse();
        fire_after(60, 2'd0);
        level = 4'd7;
        done_pulse();

        // Level 7 cooldown, then a mid-cooldown switch to level 3
        alive = 3'b111;
        fire_after(12, 2'd1); done_pulse();
        run_ticks(5);
        @(negedge pclk);
        level = 4'd3;
        en_x[32:22] = 11'd2040;
        en_y[32:22] = 11'd100;
        fire_after(36, 2'd2);
        check("sat_x", 32'(fire_x), 32'd2047);
        check("off_y", 32'(fire_y), 32'd132);

        // Watchdog ends the flight with no missile_done
        run_ticks(179);
        #1 check("wd_busy_179", 32'(busy), 32'd1);
        run_ticks(1);
        #1 check("wd_busy_180", 32'(busy), 32'd0);
        fire_after(36, 2'd0);
        done_pulse();

        // All dead in cooldown: back to IDLE, no fire
        @(negedge pclk) alive = 3'b000;
        @(negedge pclk); #1;
        check("idle_state", 32'(int'(dut.state)), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        run_ticks(70);
        @(negedge pclk) alive = 3'b111;

        // Selected shooter dies after SELECT: reselect picks the next alive one
        run_ticks(35);
        push_exp(2'd2);
        run_ticks(1);
        #1 check("kill_t1", 32'(fire), 32'd0);
        @(negedge pclk) alive = 3'b101;
        #1 check("kill_nofire", 32'(fire), 32'd0);
        check("kill_busy", 32'(busy), 32'd0);
        @(negedge pclk); #1;
        check("kill_reselect", 32'(fire), 32'd0);
        @(negedge pclk); #1;
        check("kill_fire", 32'(fire), 32'd1);
        check("kill_id", 32'(fire_id), 32'd2);

        // Reset pulse mid-flight
        @(negedge pclk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(int'(dut.state)), 32'd0);
        check("mid_rst_x", 32'(fire_x), 32'd0);
        check("mid_rst_id", 32'(fire_id), 32'd0);
        @(negedge pclk) rst = 1'b1;
        repeat (10) @(negedge pclk);
        #1;
        check("post_rst_state", 32'(int'(dut.state)), 32'd1);
        check("post_rst_fire", 32'(fire), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
